rs_branch: RTL and testbench
============================

// Module: rs_branch
// PURPOSE
//  Branch reservation station: producer side of the branch-execute issue interface. Buffers branches from the
//  allocator in program order and snoops the CDB to resolve operand tags. Drives the head entry's
//  busy/op/pc/offset/tag/data onto the branch execute unit and retires the head when that unit returns
//  busy=0. Sits between allocator/decoder and branch execute.
// PARAMETERS
//  DEPTH      4    entries; power of two, >=2
//  PTR_W      2    log2(DEPTH)
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          synchronous reset, active-high
//  rdy            in   1          global ready; low freezes all state
//  alloc_en_in    in   1          allocator writes one branch this cycle
//  alloc_op_in    in   `sinst_t   BEQ/BNE/BLT/BGE/BLTU/BGEU
//  alloc_pc_in    in   `addr_t    branch pc
//  alloc_off_in   in   `dword_t   sign-extended B-immediate
//  alloc_tagx_in  in   `regtag_t  rs1 tag, `UNLOCKED if value ready
//  alloc_tagy_in  in   `regtag_t  rs2 tag, `UNLOCKED if value ready
//  alloc_datax_in in   `dword_t   rs1 value (valid iff tagx==`UNLOCKED)
//  alloc_datay_in in   `dword_t   rs2 value (valid iff tagy==`UNLOCKED)
//  full_out       out  1          no free entry; allocator must not assert alloc_en_in
//  cdb_en_in      in   1          CDB broadcast valid
//  cdb_tag_in     in   `regtag_t  producing tag
//  cdb_data_in    in   `dword_t   produced value
//  branch_busy_out  out 1         head valid
//  branch_op_out    out `sinst_t  head op
//  pc_out           out `addr_t   head pc
//  offset_out       out `dword_t  head offset
//  branch_tagx_out  out `regtag_t head rs1 tag
//  branch_tagy_out  out `regtag_t head rs2 tag
//  branch_datax_out out `dword_t  head rs1 data
//  branch_datay_out out `dword_t  head rs2 data
//  branch_busy_in   in  1         feedback from execute: 0 = head consumed (or nothing held)
// BEHAVIOUR
//  - Reset (rst=1 at edge): head=tail=count=0, all valid bits 0; head outputs read busy=0, tags `UNLOCKED,
//    op/pc/offset/data 0; full_out=0. Reset wins over every other input, including mid-issue.
//  - rdy=0: no alloc, pop or snoop update; outputs hold. Upstream is equally frozen; CDB is not replayed.
//  - Head outputs combinational from registered head entry; zeroed/`UNLOCKED when empty.
//  - Pop: at edge with rdy=1, branch_busy_out=1 and branch_busy_in=0 -> head invalidated, head+1 (mod DEPTH),
//    count-1. Issue-to-pop latency 0 cycles when both tags `UNLOCKED at head; next head presented next cycle.
//  - Alloc: alloc_en_in=1, rdy=1, !full_out -> write at tail, tail+1 mod DEPTH, count+1. Alloc while full:
//    ignored, no state change (bench flags it as protocol error).
//  - Alloc and pop in same cycle: both take effect, count unchanged; legal when full only if not full_out.
//  - Snoop: every valid entry with tagx==cdb_tag_in (cdb_en_in=1) latches datax=cdb_data_in, tagx=`UNLOCKED;
//    same for y. Also applied to the entry being allocated this cycle (bypass: incoming tag compared
//    against cdb_tag_in before write). Both operands may match the same broadcast.
//  - Snoop on the head in its pop cycle is harmless: entry is invalidated.
//  - Order strict FIFO; no entry issues before an older one. No flush port: front end stalls on branches.
//  - full_out = (count==DEPTH), registered-state derived; count width PTR_W+1.
// STRUCTURE
//  - Shared defines: `addr_t, `dword_t, `sinst_t, `regtag_t, `UNLOCKED, branch op encodings.
//  - One sub-module: rs_branch_entry (one slot: valid, fields, per-operand CDB snoop/bypass logic);
//    top holds pointers, count, alloc/pop control and head mux.
// TESTING
//  - Reset: drive rst 1 cycle -> busy_out=0, tags `UNLOCKED, full_out=0; rst mid-stream with 3 entries -> empty next cycle.
//  - Ready alloc: BEQ pc=0x100 off=0x20 tags `UNLOCKED data 5/5, busy_in tied to model -> busy_out=1 next cycle, pops same edge.
//  - Snoop: alloc BNE tagx=3 tagy=`UNLOCKED; 2 cycles later cdb tag=3 data=7 -> head tagx=`UNLOCKED datax=7, pops next edge.
//  - Bypass: alloc with tagy=4 while cdb_en tag=4 data=0x55 same cycle -> stored tagy=`UNLOCKED datay=0x55.
//  - Full/wrap: alloc 4 blocked heads -> full_out=1; 5th alloc ignored; release all, alloc 4 more -> pointers wrap, FIFO order kept.
//  - rdy=0 for 3 cycles with alloc_en and cdb_en active -> no state change; resumes identically after rdy=1.

Source files
------------

// File: rtl/rs_branch_pkg.sv
// Shared types for the branch reservation station: operand/address widths, branch op
// encodings (funct3 values), the tag value meaning "operand ready", and the slot record.
package rs_branch_pkg;

    localparam int DEPTH    = 4;
    localparam int PTR_W    = 2;
    localparam int ADDR_W   = 32;
    localparam int DWORD_W  = 32;
    localparam int REGTAG_W = 5;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [DWORD_W-1:0]  dword_t;
    typedef logic [REGTAG_W-1:0] regtag_t;

    localparam regtag_t UNLOCKED = '0;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } sinst_t;

    typedef struct packed {
        sinst_t  op;
        addr_t   pc;
        dword_t  off;
        regtag_t tagx;
        regtag_t tagy;
        dword_t  datax;
        dword_t  datay;
    } rs_entry_t;

    localparam rs_entry_t EMPTY_ENTRY = '{
        op: BR_BEQ, pc: '0, off: '0,
        tagx: UNLOCKED, tagy: UNLOCKED, datax: '0, datay: '0
    };

    // A ready operand never matches: UNLOCKED is not a producer tag.
    function automatic logic snoop_hit(input regtag_t tag, input logic cdb_en,
                                       input regtag_t cdb_tag);
        return cdb_en && (tag != UNLOCKED) && (tag == cdb_tag);
    endfunction

endpackage

// File: rtl/rs_branch_if.sv
// Allocator, CDB and branch-execute signals of the branch reservation station.
// master = surrounding pipeline, slave = the reservation station.
interface rs_branch_if;
    import rs_branch_pkg::*;

    logic    alloc_en_in;
    sinst_t  alloc_op_in;
    addr_t   alloc_pc_in;
    dword_t  alloc_off_in;
    regtag_t alloc_tagx_in;
    regtag_t alloc_tagy_in;
    dword_t  alloc_datax_in;
    dword_t  alloc_datay_in;
    logic    full_out;

    logic    cdb_en_in;
    regtag_t cdb_tag_in;
    dword_t  cdb_data_in;

    logic    branch_busy_out;
    sinst_t  branch_op_out;
    addr_t   pc_out;
    dword_t  offset_out;
    regtag_t branch_tagx_out;
    regtag_t branch_tagy_out;
    dword_t  branch_datax_out;
    dword_t  branch_datay_out;
    logic    branch_busy_in;

    modport master (
        output alloc_en_in, alloc_op_in, alloc_pc_in, alloc_off_in,
               alloc_tagx_in, alloc_tagy_in, alloc_datax_in, alloc_datay_in,
               cdb_en_in, cdb_tag_in, cdb_data_in, branch_busy_in,
        input  full_out, branch_busy_out, branch_op_out, pc_out, offset_out,
               branch_tagx_out, branch_tagy_out, branch_datax_out, branch_datay_out
    );

    modport slave (
        input  alloc_en_in, alloc_op_in, alloc_pc_in, alloc_off_in,
               alloc_tagx_in, alloc_tagy_in, alloc_datax_in, alloc_datay_in,
               cdb_en_in, cdb_tag_in, cdb_data_in, branch_busy_in,
        output full_out, branch_busy_out, branch_op_out, pc_out, offset_out,
               branch_tagx_out, branch_tagy_out, branch_datax_out, branch_datay_out
    );

endinterface

// File: rtl/rs_branch_entry.sv
// One reservation-station slot: valid bit, branch fields and per-operand CDB snoop,
// with the snoop also applied to the record being written (same-cycle bypass).
module rs_branch_entry
    import rs_branch_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      wr_en,
    input  rs_entry_t wr_data,
    input  logic      clr,
    input  logic      cdb_en,
    input  regtag_t   cdb_tag,
    input  dword_t    cdb_data,
    output logic      valid,
    output rs_entry_t data
);

    logic      valid_reg, valid_next;
    rs_entry_t entry_reg, entry_next;
    rs_entry_t src;

    always_comb begin
        src        = wr_en ? wr_data : entry_reg;
        entry_next = src;
        valid_next = valid_reg;
        if (wr_en) begin
            valid_next = 1'b1;
        end else if (clr) begin
            valid_next = 1'b0;
        end
        if (snoop_hit(src.tagx, cdb_en, cdb_tag)) begin
            entry_next.tagx  = UNLOCKED;
            entry_next.datax = cdb_data;
        end
        if (snoop_hit(src.tagy, cdb_en, cdb_tag)) begin
            entry_next.tagy  = UNLOCKED;
            entry_next.datay = cdb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            entry_reg <= EMPTY_ENTRY;
        end else if (rdy) begin
            valid_reg <= valid_next;
            entry_reg <= entry_next;
        end
    end

    assign valid = valid_reg;
    assign data  = entry_reg;

endmodule

// File: rtl/rs_branch.sv
// Branch reservation station: in-order FIFO of branches whose operand tags are resolved
// from the CDB; the head slot is presented to branch execute and retired when it drops busy.
module rs_branch
    import rs_branch_pkg::*;
#(
    parameter int DEPTH = rs_branch_pkg::DEPTH,
    parameter int PTR_W = rs_branch_pkg::PTR_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    rs_branch_if.slave bus
);

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [PTR_W:0]   count_reg;
    logic             full;
    logic             do_alloc, do_pop;
    logic             head_valid;
    rs_entry_t        alloc_entry;
    rs_entry_t        head_entry;
    logic             slot_valid [DEPTH];
    rs_entry_t        slot_data  [DEPTH];

    assign full       = (count_reg == (PTR_W+1)'(DEPTH));
    assign head_valid = slot_valid[head_reg];
    assign do_alloc   = rdy && bus.alloc_en_in && !full;
    assign do_pop     = rdy && head_valid && !bus.branch_busy_in;

    assign alloc_entry = '{
        op:    bus.alloc_op_in,
        pc:    bus.alloc_pc_in,
        off:   bus.alloc_off_in,
        tagx:  bus.alloc_tagx_in,
        tagy:  bus.alloc_tagy_in,
        datax: bus.alloc_datax_in,
        datay: bus.alloc_datay_in
    };

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            rs_branch_entry u_entry (
                .clk      (clk),
                .rst      (rst),
                .rdy      (rdy),
                .wr_en    (do_alloc && (tail_reg == PTR_W'(gi))),
                .wr_data  (alloc_entry),
                .clr      (do_pop && (head_reg == PTR_W'(gi))),
                .cdb_en   (bus.cdb_en_in),
                .cdb_tag  (bus.cdb_tag_in),
                .cdb_data (bus.cdb_data_in),
                .valid    (slot_valid[gi]),
                .data     (slot_data[gi])
            );
        end
    endgenerate

    // Pointers wrap for free because DEPTH is exactly 2**PTR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy) begin
            if (do_alloc) tail_reg <= tail_reg + 1'b1;
            if (do_pop)   head_reg <= head_reg + 1'b1;
            case ({do_alloc, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = head_valid ? slot_data[head_reg] : EMPTY_ENTRY;

    assign bus.full_out         = full;
    assign bus.branch_busy_out  = head_valid;
    assign bus.branch_op_out    = head_entry.op;
    assign bus.pc_out           = head_entry.pc;
    assign bus.offset_out       = head_entry.off;
    assign bus.branch_tagx_out  = head_entry.tagx;
    assign bus.branch_tagy_out  = head_entry.tagy;
    assign bus.branch_datax_out = head_entry.datax;
    assign bus.branch_datay_out = head_entry.datay;

endmodule

// File: tb/tb_rs_branch.sv
// Bench for rs_branch: directed scenarios plus random traffic, all compared against a
// queue-based model of the station (in-order queue, CDB resolution, bypass on insert).
module tb_rs_branch;
    import rs_branch_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy;
    always #5 clk = ~clk;

    rs_branch_if bus ();

    rs_branch dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    typedef struct {
        logic    rst, rdy, alloc_en;
        sinst_t  op;
        addr_t   pc;
        dword_t  off;
        regtag_t tx, ty;
        dword_t  dx, dy;
        logic    cdb_en;
        regtag_t ct;
        dword_t  cd;
        logic    busy_in;
    } stim_t;

    rs_entry_t model_q[$];
    int        n_cmp = 0;
    int        n_err = 0;
    int        n_proto = 0;
    logic      m_pop, m_acc;
    rs_entry_t m_new;
    stim_t     s;
    sinst_t    ops [6] = '{BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t r;
        r.rst = 1'b0; r.rdy = 1'b1; r.alloc_en = 1'b0;
        r.op = BR_BEQ; r.pc = '0; r.off = '0;
        r.tx = UNLOCKED; r.ty = UNLOCKED; r.dx = '0; r.dy = '0;
        r.cdb_en = 1'b0; r.ct = 5'd1; r.cd = '0;
        r.busy_in = 1'b1;
        return r;
    endfunction

    // A broadcast resolves an operand that is waiting on exactly that producer tag.
    function automatic rs_entry_t resolve(input rs_entry_t e);
        rs_entry_t r = e;
        if (bus.cdb_en_in && e.tagx != UNLOCKED && e.tagx == bus.cdb_tag_in) begin
            r.tagx = UNLOCKED; r.datax = bus.cdb_data_in;
        end
        if (bus.cdb_en_in && e.tagy != UNLOCKED && e.tagy == bus.cdb_tag_in) begin
            r.tagy = UNLOCKED; r.datay = bus.cdb_data_in;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
        end else if (rdy) begin
            foreach (model_q[i]) model_q[i] = resolve(model_q[i]);
            m_pop = (model_q.size() != 0) && !bus.branch_busy_in;
            m_acc = bus.alloc_en_in && (model_q.size() < DEPTH);
            if (bus.alloc_en_in && !m_acc) n_proto++;
            m_new = resolve('{op: bus.alloc_op_in, pc: bus.alloc_pc_in, off: bus.alloc_off_in,
                              tagx: bus.alloc_tagx_in, tagy: bus.alloc_tagy_in,
                              datax: bus.alloc_datax_in, datay: bus.alloc_datay_in});
            if (m_pop) begin
                $display("pop  pc=%08h op=%0d x=%08h y=%08h", model_q[0].pc, model_q[0].op,
                         model_q[0].datax, model_q[0].datay);
                void'(model_q.pop_front());
            end
            if (m_acc) model_q.push_back(m_new);
        end
    end

    task automatic check_model();
        rs_entry_t e = (model_q.size() != 0) ? model_q[0] : EMPTY_ENTRY;
        chk_eq("busy",  bus.branch_busy_out, model_q.size() != 0);
        chk_eq("full",  bus.full_out, model_q.size() == DEPTH);
        chk_eq("op",    bus.branch_op_out, e.op);
        chk_eq("pc",    bus.pc_out, e.pc);
        chk_eq("off",   bus.offset_out, e.off);
        chk_eq("tagx",  bus.branch_tagx_out, e.tagx);
        chk_eq("tagy",  bus.branch_tagy_out, e.tagy);
        if (e.tagx == UNLOCKED) chk_eq("datax", bus.branch_datax_out, e.datax);
        if (e.tagy == UNLOCKED) chk_eq("datay", bus.branch_datay_out, e.datay);
    endtask

    task automatic drive(input stim_t t);
        @(negedge clk);
        rst = t.rst; rdy = t.rdy;
        bus.alloc_en_in = t.alloc_en; bus.alloc_op_in = t.op;
        bus.alloc_pc_in = t.pc; bus.alloc_off_in = t.off;
        bus.alloc_tagx_in = t.tx; bus.alloc_tagy_in = t.ty;
        bus.alloc_datax_in = t.dx; bus.alloc_datay_in = t.dy;
        bus.cdb_en_in = t.cdb_en; bus.cdb_tag_in = t.ct; bus.cdb_data_in = t.cd;
        bus.branch_busy_in = t.busy_in;
        #1;
        check_model();
    endtask

    initial begin
        // Reset
        s = idle(); s.rst = 1'b1;
        drive(s); drive(s);
        s = idle(); drive(s);
        chk_eq("rst_busy", bus.branch_busy_out, 1'b0);
        chk_eq("rst_full", bus.full_out, 1'b0);
        chk_eq("rst_tagx", bus.branch_tagx_out, UNLOCKED);

        // Ready operands: presented next cycle, popped on that edge
        s = idle(); s.alloc_en = 1'b1; s.op = BR_BEQ; s.pc = 'h100; s.off = 'h20;
        s.dx = 5; s.dy = 5; drive(s);
        s = idle(); s.busy_in = 1'b0; drive(s);
        chk_eq("ra_busy", bus.branch_busy_out, 1'b1);
        chk_eq("ra_pc", bus.pc_out, 'h100);
        chk_eq("ra_off", bus.offset_out, 'h20);
        chk_eq("ra_datay", bus.branch_datay_out, 5);
        s = idle(); drive(s);
        chk_eq("ra_popped", bus.branch_busy_out, 1'b0);

        // CDB resolves a waiting rs1
        s = idle(); s.alloc_en = 1'b1; s.op = BR_BNE; s.pc = 'h104; s.tx = 3; s.dy = 9; drive(s);
        s = idle(); drive(s);
        chk_eq("sn_locked", bus.branch_tagx_out, 3);
        s.cdb_en = 1'b1; s.ct = 3; s.cd = 7; drive(s);
        s = idle(); s.busy_in = 1'b0; drive(s);
        chk_eq("sn_tagx", bus.branch_tagx_out, UNLOCKED);
        chk_eq("sn_datax", bus.branch_datax_out, 7);
        s = idle(); drive(s);
        chk_eq("sn_popped", bus.branch_busy_out, 1'b0);

        // Broadcast in the allocation cycle is captured by the incoming entry
        s = idle(); s.alloc_en = 1'b1; s.op = BR_BLT; s.pc = 'h108; s.ty = 4;
        s.cdb_en = 1'b1; s.ct = 4; s.cd = 'h55; drive(s);
        s = idle(); drive(s);
        chk_eq("bp_tagy", bus.branch_tagy_out, UNLOCKED);
        chk_eq("bp_datay", bus.branch_datay_out, 'h55);
        s = idle(); s.busy_in = 1'b0; drive(s);

        // Fill, overflow attempt, drain in order; second round wraps the pointers
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 4; i++) begin
                s = idle(); s.alloc_en = 1'b1; s.op = ops[i];
                s.pc = addr_t'('h200 + round * 'h100 + i * 4); drive(s);
            end
            s = idle(); drive(s);
            chk_eq("fw_full", bus.full_out, 1'b1);
            if (round == 0) begin
                s = idle(); s.alloc_en = 1'b1; s.pc = 'h999; drive(s);
                s = idle(); drive(s);
                chk_eq("fw_still_full", bus.full_out, 1'b1);
            end
            for (int i = 0; i < 4; i++) begin
                s = idle(); s.busy_in = 1'b0; drive(s);
                chk_eq("fw_order", bus.pc_out, 'h200 + round * 'h100 + i * 4);
            end
            s = idle(); drive(s);
            chk_eq("fw_empty", bus.branch_busy_out, 1'b0);
        end

        // Freeze: nothing moves while rdy is low, broadcast is not replayed
        s = idle(); s.alloc_en = 1'b1; s.pc = 'h300; s.tx = 2; drive(s);
        s.pc = 'h304; s.tx = UNLOCKED; drive(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.rdy = 1'b0; s.alloc_en = 1'b1; s.pc = 'h3ff;
            s.cdb_en = 1'b1; s.ct = 2; s.cd = 'h77; s.busy_in = 1'b0; drive(s);
            chk_eq("frz_pc", bus.pc_out, 'h300);
            chk_eq("frz_tagx", bus.branch_tagx_out, 2);
        end
        s = idle(); drive(s);
        chk_eq("frz_after_tagx", bus.branch_tagx_out, 2);
        s = idle(); s.cdb_en = 1'b1; s.ct = 2; s.cd = 'h78; drive(s);
        s = idle(); s.busy_in = 1'b0; drive(s);
        chk_eq("frz_resolved", bus.branch_datax_out, 'h78);
        drive(s); drive(s);

        // Reset mid-stream with three held entries
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.alloc_en = 1'b1; s.pc = addr_t'('h400 + i * 4); drive(s);
        end
        s = idle(); s.rst = 1'b1; s.alloc_en = 1'b1; s.busy_in = 1'b0; drive(s);
        s = idle(); drive(s);
        chk_eq("mrst_busy", bus.branch_busy_out, 1'b0);
        chk_eq("mrst_full", bus.full_out, 1'b0);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            s = idle();
            s.rst      = ($urandom_range(0, 299) == 0);
            s.rdy      = ($urandom_range(0, 9) != 0);
            s.alloc_en = ($urandom_range(0, 2) != 0) && (model_q.size() < DEPTH);
            s.op       = ops[$urandom_range(0, 5)];
            s.pc       = $urandom;
            s.off      = $urandom;
            s.tx       = ($urandom_range(0, 2) == 0) ? regtag_t'($urandom_range(1, 7)) : UNLOCKED;
            s.ty       = ($urandom_range(0, 2) == 0) ? regtag_t'($urandom_range(1, 7)) : UNLOCKED;
            s.dx       = $urandom;
            s.dy       = $urandom;
            s.cdb_en   = $urandom_range(0, 1);
            s.ct       = regtag_t'($urandom_range(1, 7));
            s.cd       = $urandom;
            s.busy_in  = ($urandom_range(0, 2) != 0);
            drive(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
